// File: rtl/axi_id_gen_pkg.sv
// Shared types and helpers for the AXI ID remap table.
// Slot fields are sized to the widest supported config; the top uses the low bits.
package axi_id_gen_pkg;

  localparam int MAX_ID_W  = 32;
  localparam int MAX_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_CNT_W-1:0] cnt;
  } slot_t;

endpackage

// File: rtl/axi_id_gen_ffs.sv
// Lowest-set-bit priority encoder.
// Returns the index of the lowest asserted request and a found flag.
module axi_id_gen_ffs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign found_o = |req_i;

endmodule

// File: rtl/axi_id_gen.sv
// AXI ID remap table: wide master IDs onto compact slave IDs, restored on response.
// Optional sticky protocol checking is built when ID_GEN_ERR_CHECK_EN is defined.
module axi_id_gen
  import axi_id_gen_pkg::*;
#(
  parameter int ID_WIDTH_IN  = 8,
  parameter int ID_WIDTH_OUT = 6,
  parameter int N_ENTRY      = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    incr_i,
  input  logic [ID_WIDTH_IN-1:0]  ID_i,
  output logic [ID_WIDTH_OUT-1:0] ID_o,
  output logic                    full_o,
  input  logic                    release_ID_i,
  input  logic [ID_WIDTH_OUT-1:0] BID_i,
  output logic [ID_WIDTH_IN-1:0]  BID_o,
  output logic                    empty_o,
  output logic                    err_o
);

  localparam int IW = idx_w(N_ENTRY);
  localparam logic [MAX_CNT_W-1:0] CNT_SAT =
    MAX_CNT_W'((2 ** CNT_WIDTH) - 1);
  localparam logic [MAX_CNT_W-1:0] CNT_ONE = MAX_CNT_W'(1);

  slot_t tbl_q [N_ENTRY];
  slot_t tbl_d [N_ENTRY];

  logic [N_ENTRY-1:0] free_vec;
  logic [N_ENTRY-1:0] vld_vec;
  logic [IW-1:0]      free_idx;
  logic               free_found;
  logic [IW-1:0]      hit_idx;
  logic               hit;
  logic [IW-1:0]      sel_idx;
  logic               full;
  logic               acc;
  logic [IW-1:0]      bid_idx;
  logic               bid_ok;
  logic               rel_ok;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      vld_vec[i]  = tbl_q[i].valid;
      free_vec[i] = ~tbl_q[i].valid;
      if (tbl_q[i].valid &&
          tbl_q[i].id == MAX_ID_W'(ID_i)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  axi_id_gen_ffs #(
    .N (N_ENTRY),
    .W (IW)
  ) u_ffs (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  // An already-mapped ID must stay on its slot to keep same-ID order.
  always_comb begin
    if (hit) begin
      sel_idx = hit_idx;
      full    = (tbl_q[hit_idx].cnt == CNT_SAT);
    end else begin
      sel_idx = free_idx;
      full    = ~free_found;
    end
  end

  always_comb begin
    ID_o = '0;
    if (!full) ID_o[IW-1:0] = sel_idx;
  end

  assign full_o  = full;
  assign empty_o = ~(|vld_vec);
  assign acc     = incr_i & ~full;

  assign bid_idx = BID_i[IW-1:0];
  assign bid_ok  = ((BID_i >> IW) == '0) &&
                   ({1'b0, bid_idx} < (IW+1)'(N_ENTRY));
  assign rel_ok  = release_ID_i & bid_ok &
                   tbl_q[bid_idx].valid;

  assign BID_o = bid_ok ?
                 tbl_q[bid_idx].id[ID_WIDTH_IN-1:0] : '0;

  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      tbl_d[i] = tbl_q[i];
      if (acc && sel_idx == IW'(i) &&
          !(rel_ok && bid_idx == IW'(i))) begin
        tbl_d[i].cnt = tbl_q[i].cnt + CNT_ONE;
        if (!tbl_q[i].valid) tbl_d[i].id = MAX_ID_W'(ID_i);
      end else if (rel_ok && bid_idx == IW'(i) &&
                   !(acc && sel_idx == IW'(i))) begin
        tbl_d[i].cnt = tbl_q[i].cnt - CNT_ONE;
      end
      tbl_d[i].valid = (tbl_d[i].cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRY; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) tbl_q[i] <= tbl_d[i];
    end
  end

`ifdef ID_GEN_ERR_CHECK_EN
  logic err_q;
  logic err_d;

  assign err_d = err_q |
                 (release_ID_i & ~rel_ok) |
                 (incr_i & full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
